perf_counter_bank: RTL and testbench

Parametrised performance-counter bank for the pipelined CPU. It keeps one free-running cycle counter plus `NUM_EVENTS` independently gated event counters, each configurable to wrap or saturate. The bank supports an atomic snapshot into shadow registers and a registered, select-addressed readout that feeds the board display/statistics path. It sits beside the pipeline and takes single-cycle event strobes: jump, branch-taken, load-use stall, and similar.

---
 rtl/perf_pkg.sv | 12 +
 rtl/perf_counter_cell.sv | 54 +++++
 rtl/perf_counter_bank.sv | 77 +++++++
 tb/tb_perf_counter_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants and helpers for the performance-counter bank.
package perf_pkg;

   localparam int PERF_WRAP = 0;
   localparam int PERF_SAT  = 1;

   // Width of the readout select: channel 0 is the cycle counter, 1..n are event channels.
   function automatic int perf_sel_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One counter channel: live counter, shadow copy and sticky overflow flag.
module perf_counter_cell
   import perf_pkg::*;
#(
   parameter int CNT_WIDTH = 32,
   parameter int SATURATE  = PERF_WRAP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 clr,
   input  logic                 snap,
   output logic [CNT_WIDTH-1:0] live,
   output logic [CNT_WIDTH-1:0] shadow,
   output logic                 ovf
);

   localparam logic [CNT_WIDTH-1:0] LP_ALL_ONES = '1;

   logic [CNT_WIDTH-1:0] r_live;
   logic [CNT_WIDTH-1:0] r_shadow;
   logic                 r_ovf;

   // Shadow captures the pre-edge live value; clear beats any same-edge increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_live   <= '0;
         r_shadow <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (snap) begin
            r_shadow <= r_live;
         end
         if (clr) begin
            r_live <= '0;
            r_ovf  <= 1'b0;
         end else if (inc) begin
            if (r_live == LP_ALL_ONES) begin
               r_ovf <= 1'b1;
               if (SATURATE == PERF_WRAP) begin
                  r_live <= '0;
               end
            end else begin
               r_live <= r_live + 1'b1;
            end
         end
      end
   end

   assign live   = r_live;
   assign shadow = r_shadow;
   assign ovf    = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus gated event counters with atomic snapshot and registered readout.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int                    NUM_EVENTS     = 4,
   parameter int                    CNT_WIDTH      = 32,
   parameter int                    SATURATE       = PERF_WRAP,
   parameter logic [NUM_EVENTS-1:0] STOP_GATE_MASK = '1,
   parameter int                    SEL_W          = perf_sel_w(NUM_EVENTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stop,
   input  logic                  clr,
   input  logic                  snap,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic [SEL_W-1:0]      rd_sel,
   input  logic                  rd_live,
   output logic [CNT_WIDTH-1:0]  rd_data,
   output logic [NUM_EVENTS:0]   ovf
);

   logic [NUM_EVENTS:0]  w_inc;
   logic [NUM_EVENTS:0]  w_ovf;
   logic [CNT_WIDTH-1:0] w_live   [NUM_EVENTS+1];
   logic [CNT_WIDTH-1:0] w_shadow [NUM_EVENTS+1];
   logic [CNT_WIDTH-1:0] w_rd_mux;
   logic [CNT_WIDTH-1:0] r_rd_data;

   // Cycle counter runs while the CPU is not halted; gated channels also pause on halt.
   always_comb begin
      w_inc    = '0;
      w_inc[0] = ~stop;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         w_inc[i+1] = event_i[i] & ~(STOP_GATE_MASK[i] & stop);
      end
   end

   for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cell
      perf_counter_cell #(
         .CNT_WIDTH (CNT_WIDTH),
         .SATURATE  (SATURATE)
      ) u_cell (
         .clk    (clk),
         .rst    (rst),
         .inc    (w_inc[g]),
         .clr    (clr),
         .snap   (snap),
         .live   (w_live[g]),
         .shadow (w_shadow[g]),
         .ovf    (w_ovf[g])
      );
   end

   // Select-addressed read mux; selects past the last channel read as zero.
   always_comb begin
      w_rd_mux = '0;
      for (int i = 0; i <= NUM_EVENTS; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            w_rd_mux = rd_live ? w_live[i] : w_shadow[i];
         end
      end
   end

   // Readout register gives one cycle of read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_mux;
      end
   end

   assign rd_data = r_rd_data;
   assign ovf     = w_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three configurations share stimulus, checked against a count model.
module tb_perf_counter_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stop = 1'b0;
   logic       clr = 1'b0;
   logic       snap = 1'b0;
   logic [3:0] ev = 4'b0;
   logic [2:0] rd_sel = 3'd0;
   logic       rd_live = 1'b1;

   logic [31:0] rd_a;
   logic [7:0]  rd_w;
   logic [7:0]  rd_s;
   logic [4:0]  ovf_a, ovf_w, ovf_s;

   logic [31:0] obs_rd  [3];
   logic [4:0]  obs_ovf [3];
   assign obs_rd[0]  = rd_a;
   assign obs_rd[1]  = {24'd0, rd_w};
   assign obs_rd[2]  = {24'd0, rd_s};
   assign obs_ovf[0] = ovf_a;
   assign obs_ovf[1] = ovf_w;
   assign obs_ovf[2] = ovf_s;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(32), .SATURATE(0), .STOP_GATE_MASK(4'b0001)) dut_a (
      .clk(clk), .rst(rst), .stop(stop), .clr(clr), .snap(snap), .event_i(ev),
      .rd_sel(rd_sel), .rd_live(rd_live), .rd_data(rd_a), .ovf(ovf_a));
   perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(8), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .stop(stop), .clr(clr), .snap(snap), .event_i(ev),
      .rd_sel(rd_sel), .rd_live(rd_live), .rd_data(rd_w), .ovf(ovf_w));
   perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(8), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .stop(stop), .clr(clr), .snap(snap), .event_i(ev),
      .rd_sel(rd_sel), .rd_live(rd_live), .rd_data(rd_s), .ovf(ovf_s));

   // Reference model: counts as plain integers, modulo or clamped at 2^W.
   int          cfg_w    [3] = '{32, 8, 8};
   bit          cfg_sat  [3] = '{1'b0, 1'b0, 1'b1};
   logic [3:0]  cfg_mask [3] = '{4'b0001, 4'b1111, 4'b1111};
   longint unsigned m_live   [3][5];
   longint unsigned m_shadow [3][5];
   longint unsigned m_rd     [3];
   logic [4:0]      m_ovf    [3];

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         for (int c = 0; c < 5; c++) begin
            m_live[d][c]   = 0;
            m_shadow[d][c] = 0;
         end
         m_rd[d]  = 0;
         m_ovf[d] = '0;
      end
   endtask

   task automatic model_edge();
      for (int d = 0; d < 3; d++) begin
         longint unsigned modulus = 64'd1 << cfg_w[d];
         m_rd[d] = 0;
         if (rd_sel <= 3'd4) m_rd[d] = rd_live ? m_live[d][rd_sel] : m_shadow[d][rd_sel];
         if (snap) for (int c = 0; c < 5; c++) m_shadow[d][c] = m_live[d][c];
         if (clr) begin
            for (int c = 0; c < 5; c++) m_live[d][c] = 0;
            m_ovf[d] = '0;
         end else begin
            for (int c = 0; c < 5; c++) begin
               bit counts = (c == 0) ? !stop : (ev[c-1] && !(cfg_mask[d][c-1] && stop));
               if (counts) begin
                  longint unsigned nxt = m_live[d][c] + 1;
                  if (nxt >= modulus) begin
                     m_ovf[d][c] = 1'b1;
                     nxt = cfg_sat[d] ? modulus - 1 : nxt - modulus;
                  end
                  m_live[d][c] = nxt;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (obs_rd[d] !== 32'd0) begin
            n_fail++; $display("FAIL reset_rd dut%0d: got %0h expected 0", d, obs_rd[d]);
         end
         n_cmp++;
         if (obs_ovf[d] !== 5'd0) begin
            n_fail++; $display("FAIL reset_ovf dut%0d: got %b expected 00000", d, obs_ovf[d]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_cycle_count();
      stop = 1'b0; ev = '0; rd_sel = 3'd0; rd_live = 1'b1;
      repeat (10) tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (obs_rd[d] !== 32'd10 || 32'(m_rd[d]) !== 32'd10) begin
            n_fail++; $display("FAIL cycle_count dut%0d: got %0d expected 10 (model %0d)", d, obs_rd[d], m_rd[d]);
         end
         n_cmp++;
         if (obs_ovf[d] !== 5'd0) begin
            n_fail++; $display("FAIL cycle_ovf dut%0d: got %b expected 00000", d, obs_ovf[d]);
         end
      end
   endtask

   task automatic test_stop_gate();
      logic [31:0] want [3] = '{32'd0, 32'd5, 32'd0};
      logic [2:0]  sels [3] = '{3'd1, 3'd3, 3'd0};
      clr = 1'b1; tick(); clr = 1'b0;
      stop = 1'b1; ev = 4'b0101;
      repeat (5) tick();
      ev = '0; rd_live = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rd_sel = sels[k];
         tick();
         n_cmp++;
         if (rd_a !== want[k]) begin
            n_fail++; $display("FAIL stop_gate sel%0d: got %0d expected %0d", sels[k], rd_a, want[k]);
         end
         for (int d = 1; d < 3; d++) begin
            n_cmp++;
            if (obs_rd[d] !== 32'(m_rd[d])) begin
               n_fail++; $display("FAIL stop_gate_all dut%0d sel%0d: got %0d expected %0d", d, sels[k], obs_rd[d], m_rd[d]);
            end
         end
      end
      stop = 1'b0;
   endtask

   task automatic test_overflow();
      logic [31:0] want [3] = '{32'd257, 32'd1, 32'd255};
      logic        wovf [3] = '{1'b0, 1'b1, 1'b1};
      clr = 1'b1; tick(); clr = 1'b0;
      stop = 1'b0; ev = 4'b0001;
      repeat (257) tick();
      ev = '0; stop = 1'b1; rd_sel = 3'd1; rd_live = 1'b1;
      tick();
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (obs_rd[d] !== want[d]) begin
            n_fail++; $display("FAIL overflow_count dut%0d: got %0d expected %0d", d, obs_rd[d], want[d]);
         end
         n_cmp++;
         if (obs_ovf[d][1] !== wovf[d] || obs_ovf[d] !== m_ovf[d]) begin
            n_fail++; $display("FAIL overflow_flag dut%0d: got %b expected %b", d, obs_ovf[d], m_ovf[d]);
         end
      end
      stop = 1'b0;
   endtask

   task automatic test_snap_clr();
      clr = 1'b1; tick(); clr = 1'b0;
      stop = 1'b0; ev = 4'b0001;
      repeat (7) tick();
      snap = 1'b1; clr = 1'b1;
      tick();
      snap = 1'b0; clr = 1'b0; ev = '0; stop = 1'b1;
      rd_sel = 3'd1; rd_live = 1'b1;
      tick();
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (obs_rd[d] !== 32'd0) begin
            n_fail++; $display("FAIL snapclr_live dut%0d: got %0d expected 0", d, obs_rd[d]);
         end
         n_cmp++;
         if (obs_ovf[d] !== 5'd0) begin
            n_fail++; $display("FAIL snapclr_ovf dut%0d: got %b expected 00000", d, obs_ovf[d]);
         end
      end
      rd_live = 1'b0;
      tick();
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (obs_rd[d] !== 32'd7) begin
            n_fail++; $display("FAIL snapclr_shadow dut%0d: got %0d expected 7", d, obs_rd[d]);
         end
      end
      stop = 1'b0; rd_live = 1'b1;
   endtask

   task automatic test_async_reset();
      stop = 1'b0; ev = 4'b1111; rd_sel = 3'd0; rd_live = 1'b1; snap = 1'b1;
      repeat (4) tick();
      snap = 1'b0; ev = '0;
      #2 rst = 1'b1;
      model_reset();
      #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (obs_rd[d] !== 32'd0 || obs_ovf[d] !== 5'd0) begin
            n_fail++; $display("FAIL async_reset dut%0d: got rd %0d ovf %b expected 0", d, obs_rd[d], obs_ovf[d]);
         end
      end
      #1 rst = 1'b0;
      stop = 1'b1;
      for (int c = 0; c < 10; c++) begin
         rd_sel = 3'(c % 5); rd_live = (c < 5);
         tick();
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_rd[d] !== 32'd0) begin
               n_fail++; $display("FAIL post_reset dut%0d sel%0d live%0d: got %0d expected 0", d, rd_sel, rd_live, obs_rd[d]);
            end
         end
      end
      stop = 1'b0;
   endtask

   task automatic test_rd_sel_oob();
      stop = 1'b0; ev = 4'b1111; snap = 1'b1;
      repeat (3) tick();
      snap = 1'b0; ev = '0;
      for (int k = 0; k < 6; k++) begin
         rd_sel = 3'(5 + k % 3); rd_live = k[0];
         tick();
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_rd[d] !== 32'd0) begin
               n_fail++; $display("FAIL rd_sel_oob dut%0d sel%0d: got %0d expected 0", d, rd_sel, obs_rd[d]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         stop    = ($urandom_range(0, 3) == 0);
         clr     = ($urandom_range(0, 63) == 0);
         snap    = ($urandom_range(0, 7) == 0);
         ev      = 4'($urandom);
         rd_sel  = 3'($urandom_range(0, 7));
         rd_live = 1'($urandom);
         tick();
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_rd[d] !== 32'(m_rd[d])) begin
               n_fail++; $display("FAIL random_rd dut%0d cyc%0d: got %0h expected %0h", d, n, obs_rd[d], m_rd[d]);
            end
            n_cmp++;
            if (obs_ovf[d] !== m_ovf[d]) begin
               n_fail++; $display("FAIL random_ovf dut%0d cyc%0d: got %b expected %b", d, n, obs_ovf[d], m_ovf[d]);
            end
         end
      end
      clr = 1'b0; snap = 1'b0; ev = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_cycle_count();
      test_stop_gate();
      test_overflow();
      test_snap_clr();
      test_async_reset();
      test_rd_sel_oob();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
